// File: rtl/plab4_net_domain_slot_arb_pkg.sv
// rtl/plab4_net_domain_slot_arb_pkg.sv - shared net defines for the domain slot arbiter
package plab4_net_domain_slot_arb_pkg;

    localparam logic DOMAIN_L = 1'b0;
    localparam logic DOMAIN_H = 1'b1;

    typedef enum logic {
        SLOT_L = 1'b0,
        SLOT_H = 1'b1
    } slot_state_e;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/plab4_net_domain_rr_pick.sv
// rtl/plab4_net_domain_rr_pick.sv - combinational cyclic priority picker
module plab4_net_domain_rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [PW:0]    sum;
    logic           found;

    // Rotating by the pointer turns "first at or after ptr" into "first set bit".
    assign doubled = {eligible, eligible} >> ptr;
    assign rotated = doubled[N-1:0];

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (PW+1)'(k);
                if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
                idx   = sum[PW-1:0];
            end
        end
        if (found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/plab4_net_domain_slot_arb.sv
// rtl/plab4_net_domain_slot_arb.sv - time-partitioned L/H output arbiter; guard via PLAB4_NET_DOMAIN_SLOT_ARB_GUARD_EN
module plab4_net_domain_slot_arb
    import plab4_net_domain_slot_arb_pkg::*;
#(
    parameter int p_num_reqs  = 3,
    parameter int p_slot_len  = 4,
    parameter int p_guard_len = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [p_num_reqs-1:0] reqs,
    input  logic [p_num_reqs-1:0] reqs_domain,
    input  logic                  out_rdy,
    output logic [p_num_reqs-1:0] grants,
    output logic                  out_val,
    output logic [1:0]            xbar_sel,
    output logic                  out_domain,
    output logic                  slot_last
);

    localparam int PW = (clog2(p_num_reqs) < 1) ? 1 : clog2(p_num_reqs);
    localparam int SW = (clog2(p_slot_len) < 1) ? 1 : clog2(p_slot_len);
`ifdef PLAB4_NET_DOMAIN_SLOT_ARB_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif
    localparam int GUARD_LEN = GUARD_EN ? p_guard_len : 0;

    slot_state_e            cur_domain, domain_nxt;
    logic [SW-1:0]          slot_cnt, slot_cnt_nxt;
    logic [PW-1:0]          ptr_l, ptr_h, ptr_l_nxt, ptr_h_nxt;
    logic [PW-1:0]          ptr_act, ptr_adv, pick_idx;
    logic [p_num_reqs-1:0]  dom_match, eligible, pick_grant;
    logic                   is_last, in_guard, is_h;

    assign is_h      = (cur_domain == SLOT_H);
    assign is_last   = (int'(slot_cnt) == p_slot_len - 1);
    assign in_guard  = (GUARD_LEN != 0) && (int'(slot_cnt) >= p_slot_len - GUARD_LEN);
    assign dom_match = ~(reqs_domain ^ {p_num_reqs{is_h}});
    assign eligible  = reqs & dom_match & {p_num_reqs{out_rdy & ~in_guard}};
    assign ptr_act   = is_h ? ptr_h : ptr_l;
    assign ptr_adv   = (int'(pick_idx) == p_num_reqs - 1) ? '0 : pick_idx + 1'b1;

    plab4_net_domain_rr_pick #(
        .N  (p_num_reqs),
        .PW (PW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_act),
        .grant    (pick_grant),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_domain <= SLOT_L;
            slot_cnt   <= '0;
            ptr_l      <= '0;
            ptr_h      <= '0;
        end else begin
            cur_domain <= domain_nxt;
            slot_cnt   <= slot_cnt_nxt;
            ptr_l      <= ptr_l_nxt;
            ptr_h      <= ptr_h_nxt;
        end
    end

    // A grant on the wrap cycle still belongs to the outgoing domain's pointer.
    always_comb begin
        slot_cnt_nxt = is_last ? '0 : slot_cnt + 1'b1;
        domain_nxt   = cur_domain;
        if (is_last) domain_nxt = is_h ? SLOT_L : SLOT_H;
        ptr_l_nxt = ptr_l;
        ptr_h_nxt = ptr_h;
        if (|pick_grant) begin
            if (is_h) ptr_h_nxt = ptr_adv;
            else      ptr_l_nxt = ptr_adv;
        end
    end

    // Outputs are forced quiet while reset is held, independent of inputs.
    always_comb begin
        grants     = reset ? pick_grant : '0;
        out_val    = reset & (|pick_grant);
        xbar_sel   = reset ? 2'(pick_idx) : 2'b00;
        out_domain = reset ? (is_h ? DOMAIN_H : DOMAIN_L) : DOMAIN_L;
        slot_last  = reset & is_last;
    end

endmodule

// File: tb/tb_plab4_net_domain_slot_arb.sv
// tb/tb_plab4_net_domain_slot_arb.sv - randomized model-checked bench for plab4_net_domain_slot_arb
module tb_plab4_net_domain_slot_arb;

    localparam int N  = 3;
    localparam int SL = 4;
    localparam int GL = 1;
`ifdef PLAB4_NET_DOMAIN_SLOT_ARB_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] reqs = '0;
    logic [N-1:0] reqs_domain = '0;
    logic         out_rdy = 1'b0;
    logic [N-1:0] grants;
    logic         out_val;
    logic [1:0]   xbar_sel;
    logic         out_domain;
    logic         slot_last;

    logic [N+4:0] dut_vec;
    logic [N+4:0] exp_vec;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int ptr[2];
    bit rst_held = 1'b1;

    assign dut_vec = {grants, out_val, xbar_sel, out_domain, slot_last};

    plab4_net_domain_slot_arb #(
        .p_num_reqs  (N),
        .p_slot_len  (SL),
        .p_guard_len (GL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reqs        (reqs),
        .reqs_domain (reqs_domain),
        .out_rdy     (out_rdy),
        .grants      (grants),
        .out_val     (out_val),
        .xbar_sel    (xbar_sel),
        .out_domain  (out_domain),
        .slot_last   (slot_last)
    );

    always #5 clk = ~clk;

    // Reference: slot domain and position follow purely from cycles since reset release.
    function automatic int model_idx();
        int dom, pos;
        bit guard;
        if (rst_held) return -1;
        dom   = (cyc / SL) % 2;
        pos   = cyc % SL;
        guard = GUARD_EN && (pos >= SL - GL);
        if (!out_rdy || guard) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr[dom] + k) % N;
            if (reqs[i] && int'(reqs_domain[i]) == dom) return i;
        end
        return -1;
    endfunction

    function automatic logic [N+4:0] model_exp();
        logic [N-1:0] g;
        int idx, dom;
        if (rst_held) return '0;
        idx = model_idx();
        dom = (cyc / SL) % 2;
        g = '0;
        if (idx >= 0) g[idx] = 1'b1;
        return {g, (idx >= 0), (idx >= 0) ? 2'(idx) : 2'b00, dom[0], ((cyc % SL) == SL - 1)};
    endfunction

    task automatic tick();
        int idx, dom;
        @(posedge clk);
        if (!rst_held) begin
            idx = model_idx();
            dom = (cyc / SL) % 2;
            if (idx >= 0) ptr[dom] = (idx + 1) % N;
            cyc++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rst_held = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        rst_held = 1'b0;
        cyc = 0;
        ptr[0] = 0;
        ptr[1] = 0;
    endtask

    task automatic test_reset();
        reqs = 3'b111; reqs_domain = 3'b000; out_rdy = 1'b1;
        reset = 1'b0; rst_held = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== '0) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d got=%b exp=%b", c, dut_vec, {(N+5){1'b0}});
            end
        end
        do_reset();
    endtask

    task automatic test_l_sequence();
        do_reset();
        reqs = 3'b111; reqs_domain = 3'b000; out_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_vec = model_exp();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL l_sequence cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_mixed_domains();
        do_reset();
        reqs = 3'b110; reqs_domain = 3'b100; out_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_vec = model_exp();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL mixed_domains cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_h_isolation();
        do_reset();
        out_rdy = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (((c / SL) % 2) == 1) begin
                reqs = 3'($urandom) | 3'b001;
                reqs_domain = 3'b111;
            end else begin
                reqs = 3'b111;
                reqs_domain = 3'b000;
            end
            @(negedge clk);
            exp_vec = model_exp();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL h_isolation cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_out_rdy_stall();
        do_reset();
        reqs = 3'b111; reqs_domain = 3'b000;
        for (int c = 0; c < 12; c++) begin
            out_rdy = !(c >= 1 && c <= 5);
            @(negedge clk);
            exp_vec = model_exp();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL out_rdy_stall cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_slot();
        do_reset();
        reqs = 3'b111; reqs_domain = 3'b111; out_rdy = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        reset = 1'b0;
        rst_held = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async got=%b exp=%b", dut_vec, {(N+5){1'b0}});
        end
        do_reset();
        reqs_domain = 3'b000;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp_vec = model_exp();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_mid_resume cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reqs        = 3'($urandom);
            reqs_domain = 3'($urandom);
            out_rdy     = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_vec = model_exp();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
            end
            tick();
        end
    endtask

    initial begin
        ptr[0] = 0;
        ptr[1] = 0;
        test_reset();
        test_l_sequence();
        test_mixed_domains();
        test_h_isolation();
        test_out_rdy_stall();
        test_reset_mid_slot();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/plab4_net_domain_slot_arb.md
# plab4_net_domain_slot_arb

Time-partitioned, security-domain-aware output-port arbiter for the mesh router. It replaces the plain round-robin output control wherever an output port is shared by L and H traffic. Time is split into fixed alternating L/H slots, so the grant a requester sees never depends on traffic from the other domain. It drives the output crossbar select and the per-port `out_domain` label.

## Interface
- `p_num_reqs`, 3: number of requesting input ports (2..4).
- `p_slot_len`, 4: cycles per domain slot.
- `p_guard_len`, 1: trailing cycles of each slot in which no grant is issued; must be less than `p_slot_len`.
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-low reset.
- `reqs`  in  p_num_reqs: per-input request.
- `reqs_domain`  in  p_num_reqs: per-input domain tag (0 = L, 1 = H).
- `out_rdy`  in  1: downstream ready.
- `grants`  out  p_num_reqs: one-hot grant, or zero.
- `out_val`  out  1: OR of `grants`.
- `xbar_sel`  out  2: index of the granted input; 0 when there is no grant.
- `out_domain`  out  1: domain of the current slot.
- `slot_last`  out  1: high on the final cycle of a slot.

## Operation
- State `cur_domain` ∈ {SLOT_L, SLOT_H}. Reset state is SLOT_L.
- `slot_cnt` counts 0..p_slot_len-1 every cycle unconditionally, independent of `reqs` and `out_rdy`.
- When `slot_cnt == p_slot_len-1`: `slot_cnt` wraps to 0 and `cur_domain` toggles.
- Guard window: `slot_cnt >= p_slot_len-p_guard_len`. This applies only when guard is enabled; see Configuration.
- Eligible vector: `reqs & ~(reqs_domain ^ {p_num_reqs{cur_domain}})`, gated by `out_rdy` and by not being in the guard window.
- Each domain has its own round-robin priority pointer: `ptr_l` and `ptr_h`.
  - Only the current domain's pointer is used and updated.
  - H activity can never change L arbitration order.
- Grant selection: the first eligible index at or after the active pointer, cyclically.
- Pointer update: on a grant, the active pointer becomes `granted_index+1`, wrapping to 0 after `p_num_reqs-1`. With no grant, the pointer holds.
- Requests whose domain does not match the slot are ignored. They receive no grant and remain pending until their slot; they are not queued.
- `out_domain = cur_domain`, even when there is no grant.

## Timing
- Grant is combinational from `reqs`, `reqs_domain` and `out_rdy` in the same cycle. Zero-latency handshake: a transfer occurs when `grants[i] & reqs[i] & out_rdy`.
- Registered state: `cur_domain`, `slot_cnt`, `ptr_l`, `ptr_h`. All update on the rising edge of `clk`.
- Reset (asserted low, asynchronous, at any point including mid-slot):
  - `cur_domain = L`, `slot_cnt = 0`, `ptr_l = ptr_h = 0`.
  - Outputs `grants = 0`, `out_val = 0`, `xbar_sel = 0`, `out_domain = 0`, `slot_last = 0` while reset is held.
- Boundary conditions:
  - First cycle after reset release is `slot_cnt = 0` of an L slot.
  - Domain switch takes effect on the cycle after `slot_last`.
  - Simultaneous grant and slot wrap: the pointer update is applied to the outgoing domain's pointer.
  - `out_rdy` low: no grant, pointers hold, slot timing unaffected.
  - `p_slot_len = 1` with guard disabled: domains alternate every cycle.

## Configuration
- `PLAB4_NET_DOMAIN_SLOT_ARB_GUARD_EN`
  - Defined: the guard window suppresses grants in the last `p_guard_len` cycles of every slot, draining single-cycle transfers before the domain flips.
  - Undefined: `p_guard_len` is ignored (treated as 0), and grants are allowed on every slot cycle including `slot_last`.

## Structure
- Shared net defines header holds:
  - `DOMAIN_L = 1'b0`, `DOMAIN_H = 1'b1`.
  - Slot state encodings.
  - The `clog2` helper for pointer width.
- One sub-module, `plab4_net_domain_rr_pick`: combinational cyclic priority picker.
  - Inputs: eligible vector and pointer.
  - Outputs: one-hot grant and index.
  - Instantiated once; its pointer input is muxed by `cur_domain`.

## Test plan
All scenarios use defaults (`p_slot_len=4`, `p_guard_len=1`, guard enabled).
- Reset release with `reqs=3'b111`, `reqs_domain=3'b000`, `out_rdy=1` -> grants 001, 010, 100 on cycles 0-2; none on cycle 3 (guard); none on cycles 4-7 (H slot); 001 again on cycle 8.
- `reqs=3'b110`, `reqs_domain=3'b100` -> input 1 is granted only in L slots (cycles 0-2); input 2 only in H slots (cycles 4-6); `out_domain` toggles at cycles 4 and 8.
- H slot with heavy H traffic, then L slot -> L grant order is identical to a run with no H traffic (`ptr_l` untouched).
- `out_rdy=0` for cycles 1-5 -> no grants; `slot_last` still pulses at cycles 3 and 7; arbitration resumes with the pointer unchanged.
- Reset asserted at cycle 6 mid-H slot -> outputs are 0 immediately; after release, the L slot starts at `slot_cnt 0` with `ptr_l = 0`.
- Guard disabled (macro undefined) -> grant is issued on cycle 3 (`slot_last`) with the same L requests.
